fp_mult_pipe: RTL and testbench
===============================

FP_MULT_PIPE -- requirements
Module: fp_mult_pipe

Interface
REQ-001 SHALL have parameter EXP_W, default 8, exponent field width (>=4).
REQ-002 SHALL have parameter MAN_W, default 23, stored mantissa width (>=4); W = 1+EXP_W+MAN_W and BIAS = 2^(EXP_W-1)-1.
REQ-003 SHALL have one clock and a synchronous, active-high reset; all state changes on the rising edge of clk.
REQ-004 clk  in  1  clock.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 in_valid  in  1  operand pair and rnd present.
REQ-007 in_ready  out  1  block accepts operands this cycle.
REQ-008 a, b  in  W each  operands {sign, exponent, mantissa}.
REQ-009 rnd  in  3  rounding mode: 0 IEEE_near, 1 IEEE_zero, 2 IEEE_pinf, 3 IEEE_ninf, 4 near_up, 5 away_zero; 6/7 treated as 0.
REQ-010 out_valid  out  1  z and status valid.
REQ-011 out_ready  in  1  consumer accepts result.
REQ-012 z  out  W  product.
REQ-013 status  out  6  {inexact, huge, tiny, nan, inf, zero}, bit5..bit0.

Function
REQ-014 Transfer on in_valid&in_ready (input) and on out_valid&out_ready (output); rnd sampled with its operands.
REQ-015 Three-stage pipeline: S1 register and classify operands; S2 mantissa product {1,man_a}*{1,man_b} (2*MAN_W+2 bits) and exponent sum e_a+e_b-BIAS (EXP_W+2 bits signed); S3 normalise, round, exception select into output register.
REQ-016 Latency: an input accepted in cycle N SHALL appear with out_valid=1 in cycle N+3 when out_ready stays high; throughput one per cycle.
REQ-017 in_ready = ~out_valid | out_ready; when low, all stages hold and z/status stay stable until the output transfer.
REQ-018 Results SHALL leave in acceptance order; no loss or duplication under any out_ready pattern.
REQ-019 Bubbles (invalid stage slots) SHALL be squeezed out only when the stage downstream is empty or advancing.
REQ-020 Input exponent 0 SHALL be treated as signed zero (denormals flushed, mantissa ignored).
REQ-021 Exponent all-ones, mantissa 0 = INF; mantissa nonzero = NaN.
REQ-022 Sign of z = sign_a XOR sign_b for all non-NaN results.
REQ-023 NaN input or ZERO*INF: z = canonical NaN {0, all-ones, 1 followed by zeros}, status.nan=1, other bits 0.
REQ-024 INF*nonzero: z = signed INF, status.inf=1; ZERO*finite: z = signed zero, status.zero=1.
REQ-025 Normalise: product MSB set -> shift right 1, exponent+1; guard and sticky from discarded bits.
REQ-026 Rounding: IEEE_near nearest-ties-even; IEEE_zero truncate; IEEE_pinf up if positive and inexact; IEEE_ninf up in magnitude if negative and inexact; near_up nearest, ties toward +inf; away_zero up in magnitude if inexact; mantissa carry-out renormalises, exponent+1.
REQ-027 status.inexact=1 when any discarded bit nonzero, also on overflow/underflow.
REQ-028 Overflow (rounded exponent >= 2^EXP_W-1): IEEE_near, near_up, away_zero -> signed INF; IEEE_zero -> signed MAX_NORM; IEEE_pinf -> +INF / -MAX_NORM; IEEE_ninf -> -INF / +MAX_NORM; status.huge=1, status.inf set iff INF returned.
REQ-029 Underflow (rounded exponent <= 0): away_zero, IEEE_pinf positive, IEEE_ninf negative -> signed MIN_NORM (exp 1, man 0); else signed zero with status.zero=1; status.tiny=1 in both cases.
REQ-030 MAX_NORM = exponent 2^EXP_W-2, mantissa all-ones.

Reset
REQ-031 While rst=1: all stage valids, out_valid, z, status = 0; in_ready=0.
REQ-032 First cycle after rst deasserts: in_ready=1; reset mid-stream discards all in-flight operations, none emitted afterwards.

Verification (EXP_W=8, MAN_W=23)
REQ-033 a=0x3FC00000, b=0x40000000, rnd=0 -> z=0x40400000, status=0, out_valid exactly 3 cycles after accept.
REQ-034 a=0x7F7FFFFF, b=0x40000000: rnd=0 -> z=0x7F800000, status=0b110010; rnd=1 -> z=0x7F7FFFFF, status=0b110000.
REQ-035 a=b=0x00800000: rnd=5 -> z=0x00800000, status=0b101000; rnd=0 -> z=0x00000000, status=0b101001.
REQ-036 a=0x00000000, b=0xFF800000 -> z=0x7FC00000, status=0b000100; a=0x3F800001, b=0x3F800001, rnd=1 vs 5 -> z=0x3F800002 vs 0x3F800003, inexact=1.
REQ-037 Eight back-to-back inputs, out_ready low for 5 cycles from first out_valid -> in_ready low during stall, z stable, all eight results in order.
REQ-038 rst pulsed one cycle with 3 ops in flight -> out_valid=0 next cycle, no stale results, next accepted op returns after 3 cycles.

Source files
------------

// File: rtl/fp_mult_pipe.sv
// Three-stage pipelined floating-point multiplier: flush-to-zero operands,
// six rounding modes, valid/ready handshake on input and output.
module fp_mult_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [EXP_W+MAN_W:0]     a,
    input  logic [EXP_W+MAN_W:0]     b,
    input  logic [2:0]               rnd,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [EXP_W+MAN_W:0]     z,
    output logic [5:0]               status
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int P  = 2 * MAN_W + 2;
    localparam int XW = EXP_W + 2;
    localparam logic signed [XW-1:0] BIAS_X = XW'((2 ** (EXP_W - 1)) - 1);
    localparam logic signed [XW-1:0] ONE_X  = XW'(1);
    localparam logic signed [XW-1:0] ZERO_X = XW'(0);
    localparam logic signed [XW-1:0] EMAX_X = XW'((2 ** EXP_W) - 1);

    logic                    adv_s;
    logic [EXP_W-1:0]        ea_s, eb_s;
    logic [MAN_W-1:0]        ma_s, mb_s;
    logic                    za_s, zb_s, ia_s, ib_s, na_s, nb_s;
    logic [2:0]              rnd_s;

    logic                    s1_valid_q, s1_sign_q, s1_nan_q, s1_inf_q, s1_zero_q;
    logic [EXP_W-1:0]        s1_ea_q, s1_eb_q;
    logic [MAN_W-1:0]        s1_ma_q, s1_mb_q;
    logic [2:0]              s1_rnd_q;

    logic [P-1:0]            prod_d;
    logic signed [XW-1:0]    exp_d;
    logic                    s2_valid_q, s2_sign_q, s2_nan_q, s2_inf_q, s2_zero_q;
    logic [P-1:0]            s2_prod_q;
    logic signed [XW-1:0]    s2_exp_q;
    logic [2:0]              s2_rnd_q;

    logic [MAN_W-1:0]        man_n_s, man_r_s;
    logic                    guard_s, sticky_s, inc_s, carry_s, inexact_s;
    logic signed [XW-1:0]    exp_n_s, exp_r_s;
    logic                    ovf_s, unf_s, ovf_inf_s, unf_min_s;
    logic [W-1:0]            z_d;
    logic [5:0]              status_d;
    logic                    out_valid_q;
    logic [W-1:0]            z_q;
    logic [5:0]              status_q;

    // A single advance enable: every stage moves only when the output slot frees up.
    assign in_ready  = ~rst & (~out_valid_q | out_ready);
    assign adv_s     = in_ready;
    assign out_valid = out_valid_q & ~rst;
    assign z         = z_q;
    assign status    = status_q;

    assign ea_s  = a[W-2:MAN_W];
    assign eb_s  = b[W-2:MAN_W];
    assign ma_s  = a[MAN_W-1:0];
    assign mb_s  = b[MAN_W-1:0];
    assign za_s  = (ea_s == {EXP_W{1'b0}});
    assign zb_s  = (eb_s == {EXP_W{1'b0}});
    assign ia_s  = (ea_s == {EXP_W{1'b1}}) & (ma_s == {MAN_W{1'b0}});
    assign ib_s  = (eb_s == {EXP_W{1'b1}}) & (mb_s == {MAN_W{1'b0}});
    assign na_s  = (ea_s == {EXP_W{1'b1}}) & (ma_s != {MAN_W{1'b0}});
    assign nb_s  = (eb_s == {EXP_W{1'b1}}) & (mb_s != {MAN_W{1'b0}});
    assign rnd_s = (rnd > 3'd5) ? 3'd0 : rnd;

    // S1: capture operands together with their special-value classification
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_sign_q  <= 1'b0;
            s1_nan_q   <= 1'b0;
            s1_inf_q   <= 1'b0;
            s1_zero_q  <= 1'b0;
            s1_ea_q    <= {EXP_W{1'b0}};
            s1_eb_q    <= {EXP_W{1'b0}};
            s1_ma_q    <= {MAN_W{1'b0}};
            s1_mb_q    <= {MAN_W{1'b0}};
            s1_rnd_q   <= 3'd0;
        end else if (adv_s) begin
            s1_valid_q <= in_valid;
            s1_sign_q  <= a[W-1] ^ b[W-1];
            s1_nan_q   <= na_s | nb_s | (za_s & ib_s) | (ia_s & zb_s);
            s1_inf_q   <= ia_s | ib_s;
            s1_zero_q  <= za_s | zb_s;
            s1_ea_q    <= ea_s;
            s1_eb_q    <= eb_s;
            s1_ma_q    <= ma_s;
            s1_mb_q    <= mb_s;
            s1_rnd_q   <= rnd_s;
        end
    end

    assign prod_d = P'({1'b1, s1_ma_q}) * P'({1'b1, s1_mb_q});
    assign exp_d  = $signed({2'b00, s1_ea_q}) + $signed({2'b00, s1_eb_q}) - BIAS_X;

    // S2: full-width significand product and biased exponent sum
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
            s2_sign_q  <= 1'b0;
            s2_nan_q   <= 1'b0;
            s2_inf_q   <= 1'b0;
            s2_zero_q  <= 1'b0;
            s2_prod_q  <= {P{1'b0}};
            s2_exp_q   <= ZERO_X;
            s2_rnd_q   <= 3'd0;
        end else if (adv_s) begin
            s2_valid_q <= s1_valid_q;
            s2_sign_q  <= s1_sign_q;
            s2_nan_q   <= s1_nan_q;
            s2_inf_q   <= s1_inf_q;
            s2_zero_q  <= s1_zero_q;
            s2_prod_q  <= prod_d;
            s2_exp_q   <= exp_d;
            s2_rnd_q   <= s1_rnd_q;
        end
    end

    // Normalise to one leading bit, then round with guard/sticky per mode
    always_comb begin
        man_n_s  = s2_prod_q[P-3:MAN_W];
        guard_s  = s2_prod_q[MAN_W-1];
        sticky_s = |s2_prod_q[MAN_W-2:0];
        exp_n_s  = s2_exp_q;
        if (s2_prod_q[P-1]) begin
            man_n_s  = s2_prod_q[P-2:MAN_W+1];
            guard_s  = s2_prod_q[MAN_W];
            sticky_s = |s2_prod_q[MAN_W-1:0];
            exp_n_s  = s2_exp_q + ONE_X;
        end else begin
            man_n_s  = s2_prod_q[P-3:MAN_W];
            guard_s  = s2_prod_q[MAN_W-1];
            sticky_s = |s2_prod_q[MAN_W-2:0];
            exp_n_s  = s2_exp_q;
        end
        inexact_s = guard_s | sticky_s;
        case (s2_rnd_q)
            3'd0:    inc_s = guard_s & (sticky_s | man_n_s[0]);
            3'd1:    inc_s = 1'b0;
            3'd2:    inc_s = ~s2_sign_q & inexact_s;
            3'd3:    inc_s = s2_sign_q & inexact_s;
            3'd4:    inc_s = guard_s & (sticky_s | ~s2_sign_q);
            3'd5:    inc_s = inexact_s;
            default: inc_s = guard_s & (sticky_s | man_n_s[0]);
        endcase
        {carry_s, man_r_s} = {1'b0, man_n_s} + {{MAN_W{1'b0}}, inc_s};
        if (carry_s) begin
            exp_r_s = exp_n_s + ONE_X;
        end else begin
            exp_r_s = exp_n_s;
        end
        ovf_s = (exp_r_s >= EMAX_X);
        unf_s = (exp_r_s <= ZERO_X);
        case (s2_rnd_q)
            3'd1:    ovf_inf_s = 1'b0;
            3'd2:    ovf_inf_s = ~s2_sign_q;
            3'd3:    ovf_inf_s = s2_sign_q;
            default: ovf_inf_s = 1'b1;
        endcase
        case (s2_rnd_q)
            3'd2:    unf_min_s = ~s2_sign_q;
            3'd3:    unf_min_s = s2_sign_q;
            3'd5:    unf_min_s = 1'b1;
            default: unf_min_s = 1'b0;
        endcase
    end

    // Exception select: NaN beats INF beats ZERO beats overflow/underflow
    always_comb begin
        z_d      = {W{1'b0}};
        status_d = 6'b000000;
        if (s2_nan_q) begin
            z_d      = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
            status_d = 6'b000100;
        end else if (s2_inf_q) begin
            z_d      = {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            status_d = 6'b000010;
        end else if (s2_zero_q) begin
            z_d      = {s2_sign_q, {(W-1){1'b0}}};
            status_d = 6'b000001;
        end else if (ovf_s) begin
            if (ovf_inf_s) begin
                z_d      = {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                status_d = 6'b110010;
            end else begin
                z_d      = {s2_sign_q, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
                status_d = 6'b110000;
            end
        end else if (unf_s) begin
            if (unf_min_s) begin
                z_d      = {s2_sign_q, {(EXP_W-1){1'b0}}, 1'b1, {MAN_W{1'b0}}};
                status_d = 6'b101000;
            end else begin
                z_d      = {s2_sign_q, {(W-1){1'b0}}};
                status_d = 6'b101001;
            end
        end else begin
            z_d      = {s2_sign_q, exp_r_s[EXP_W-1:0], man_r_s};
            status_d = {inexact_s, 5'b00000};
        end
    end

    // S3: output register, only overwritten by a valid result
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            z_q         <= {W{1'b0}};
            status_q    <= 6'b000000;
        end else if (adv_s) begin
            out_valid_q <= s2_valid_q;
            if (s2_valid_q) begin
                z_q      <= z_d;
                status_q <= status_d;
            end
        end
    end
endmodule

// File: tb/tb_fp_mult_pipe.sv
// Randomised and directed bench for fp_mult_pipe (EXP_W=8, MAN_W=23) with a
// scoreboard fed by an integer-arithmetic reference model.
module tb_fp_mult_pipe;
    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] a, b, z;
    logic [2:0]  rnd;
    logic [5:0]  status;

    int n_cmp = 0;
    int n_bad = 0;
    logic [37:0] exp_q[$];
    logic        ov_smp, ir_smp, acc_smp;
    logic [31:0] z_smp;
    logic [5:0]  st_smp;

    fp_mult_pipe #(.EXP_W(8), .MAN_W(23)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .rnd(rnd), .out_valid(out_valid), .out_ready(out_ready),
        .z(z), .status(status)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] expv);
        n_cmp++;
        if (got !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, expv);
        end
    endtask

    // Reference: exact integer product, round by comparing remainder to half-ulp.
    function automatic logic [37:0] model(input logic [31:0] x, input logic [31:0] y, input logic [2:0] md);
        int ex, ey, e, m, sh;
        logic sgn, xz, yz, xi, yi, xn, yn, inx, up, big;
        logic [63:0] p, q, r, half;
        ex  = int'(x[30:23]);
        ey  = int'(y[30:23]);
        sgn = x[31] ^ y[31];
        m   = (md > 3'd5) ? 0 : int'(md);
        xz = (ex == 0);  yz = (ey == 0);
        xi = (ex == 255) && (x[22:0] == 23'd0);
        yi = (ey == 255) && (y[22:0] == 23'd0);
        xn = (ex == 255) && (x[22:0] != 23'd0);
        yn = (ey == 255) && (y[22:0] != 23'd0);
        if (xn || yn || (xz && yi) || (xi && yz)) return {6'b000100, 32'h7FC00000};
        if (xi || yi) return {6'b000010, sgn, 8'hFF, 23'h0};
        if (xz || yz) return {6'b000001, sgn, 31'h0};
        p    = {40'd0, 1'b1, x[22:0]} * {40'd0, 1'b1, y[22:0]};
        sh   = p[47] ? 24 : 23;
        q    = p >> sh;
        r    = p - (q << sh);
        half = 64'd1 << (sh - 1);
        inx  = (r != 64'd0);
        case (m)
            0:       up = (r > half) || ((r == half) && q[0]);
            1:       up = 1'b0;
            2:       up = inx && !sgn;
            3:       up = inx && sgn;
            4:       up = (r > half) || ((r == half) && !sgn);
            5:       up = inx;
            default: up = 1'b0;
        endcase
        q = q + {63'd0, up};
        e = ex + ey - 127 + (sh - 23);
        if (q == (64'd1 << 24)) begin
            q = q >> 1;
            e = e + 1;
        end
        if (e >= 255) begin
            big = (m == 0) || (m == 4) || (m == 5) || ((m == 2) && !sgn) || ((m == 3) && sgn);
            if (big) return {6'b110010, sgn, 8'hFF, 23'h0};
            return {6'b110000, sgn, 8'hFE, 23'h7FFFFF};
        end
        if (e <= 0) begin
            if ((m == 5) || ((m == 2) && !sgn) || ((m == 3) && sgn)) return {6'b101000, sgn, 8'h01, 23'h0};
            return {6'b101001, sgn, 31'h0};
        end
        return {inx, 5'b00000, sgn, e[7:0], q[22:0]};
    endfunction

    function automatic logic [31:0] rand_op();
        logic [31:0] v;
        int sel;
        v   = $urandom;
        sel = $urandom_range(0, 19);
        if (sel == 0)      v[30:23] = 8'h00;
        else if (sel == 1) v[30:23] = 8'hFF;
        else if (sel == 2) begin v[30:23] = 8'hFF; v[22:0] = 23'd0; end
        else if (sel == 3) begin v[30:23] = 8'($urandom_range(100, 150)); v[22:0] = 23'h7FFFFF; end
        else if (sel == 4) begin v[30:23] = 8'($urandom_range(100, 150)); v[11:0] = 12'd0; end
        else if (sel < 12) v[30:23] = 8'($urandom_range(64, 190));
        return v;
    endfunction

    // One clock: sample at the falling edge, score transfers, return 1 after the rising edge.
    task automatic step();
        logic [37:0] e;
        @(negedge clk);
        ov_smp  = out_valid;
        ir_smp  = in_ready;
        z_smp   = z;
        st_smp  = status;
        acc_smp = in_valid & in_ready;
        if (out_valid && out_ready) begin
            check_val("sb_nonempty", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_val("sb_z", 64'(z), 64'(e[31:0]));
                check_val("sb_status", 64'(status), 64'(e[37:32]));
            end
        end
        if (acc_smp) exp_q.push_back(model(a, b, rnd));
        @(posedge clk);
        #1;
    endtask

    task automatic run_one(input string tag, input logic [31:0] x, input logic [31:0] y,
                           input logic [2:0] md, input logic [31:0] ez, input logic [5:0] es);
        int lat;
        logic [31:0] gz;
        logic [5:0]  gs;
        a = x; b = y; rnd = md; in_valid = 1'b1;
        step();
        check_val({tag, "_accept"}, 64'(acc_smp), 64'd1);
        in_valid = 1'b0;
        lat = 0; gz = 32'd0; gs = 6'd0;
        for (int k = 1; k <= 6; k++) begin
            step();
            if (ov_smp && lat == 0) begin
                lat = k; gz = z_smp; gs = st_smp;
            end
        end
        check_val({tag, "_lat"}, 64'(lat), 64'd3);
        check_val({tag, "_z"}, 64'(gz), 64'(ez));
        check_val({tag, "_status"}, 64'(gs), 64'(es));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] sa[8], sb[8];
        logic [2:0]  sr[8];
        logic [31:0] z_hold;
        int idx, stall_n, n_seen;
        logic started;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = 32'd0; b = 32'd0; rnd = 3'd0;
        step(); step();
        check_val("rst_in_ready", 64'(ir_smp), 64'd0);
        check_val("rst_out_valid", 64'(ov_smp), 64'd0);
        check_val("rst_z", 64'(z_smp), 64'd0);
        check_val("rst_status", 64'(st_smp), 64'd0);
        rst = 1'b0;
        step();
        check_val("post_rst_in_ready", 64'(ir_smp), 64'd1);

        run_one("basic",     32'h3FC00000, 32'h40000000, 3'd0, 32'h40400000, 6'b000000);
        run_one("ovf_near",  32'h7F7FFFFF, 32'h40000000, 3'd0, 32'h7F800000, 6'b110010);
        run_one("ovf_zero",  32'h7F7FFFFF, 32'h40000000, 3'd1, 32'h7F7FFFFF, 6'b110000);
        run_one("unf_away",  32'h00800000, 32'h00800000, 3'd5, 32'h00800000, 6'b101000);
        run_one("unf_near",  32'h00800000, 32'h00800000, 3'd0, 32'h00000000, 6'b101001);
        run_one("zero_inf",  32'h00000000, 32'hFF800000, 3'd0, 32'h7FC00000, 6'b000100);
        run_one("rnd_trunc", 32'h3F800001, 32'h3F800001, 3'd1, 32'h3F800002, 6'b100000);
        run_one("rnd_away",  32'h3F800001, 32'h3F800001, 3'd5, 32'h3F800003, 6'b100000);

        for (int i = 0; i < 8; i++) begin
            sa[i] = rand_op(); sb[i] = rand_op(); sr[i] = 3'($urandom_range(0, 7));
        end
        idx = 0; stall_n = 0; started = 1'b0; z_hold = 32'd0; out_ready = 1'b1;
        a = sa[0]; b = sb[0]; rnd = sr[0]; in_valid = 1'b1;
        for (int c = 0; c < 100 && (idx < 8 || exp_q.size() > 0); c++) begin
            step();
            if (acc_smp) idx++;
            if (stall_n > 0) begin
                check_val("stall_in_ready", 64'(ir_smp), 64'd0);
                if (stall_n < 5) check_val("stall_z_stable", 64'(z_smp), 64'(z_hold));
                z_hold = z_smp;
                stall_n--;
                if (stall_n == 0) out_ready = 1'b1;
            end else if (!started && ov_smp) begin
                started = 1'b1; stall_n = 5; out_ready = 1'b0;
            end
            if (idx < 8) begin
                a = sa[idx]; b = sb[idx]; rnd = sr[idx]; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
        end
        check_val("stall_all_in", 64'(idx), 64'd8);
        check_val("stall_drained", 64'(exp_q.size()), 64'd0);

        idx = 0; in_valid = 1'b0;
        for (int c = 0; c < 6000 && (idx < 400 || exp_q.size() > 0); c++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if (idx < 400) begin
                in_valid = ($urandom_range(0, 3) != 0);
                a = rand_op(); b = rand_op(); rnd = 3'($urandom_range(0, 7));
            end else begin
                in_valid = 1'b0;
            end
            step();
            if (acc_smp) idx++;
        end
        check_val("rand_all_in", 64'(idx), 64'd400);
        check_val("rand_drained", 64'(exp_q.size()), 64'd0);

        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a = rand_op(); b = rand_op(); rnd = 3'($urandom_range(0, 7)); in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0; rst = 1'b1;
        exp_q.delete();
        step();
        check_val("mid_rst_out_valid", 64'(ov_smp), 64'd0);
        check_val("mid_rst_in_ready", 64'(ir_smp), 64'd0);
        rst = 1'b0;
        n_seen = 0;
        for (int k = 0; k < 5; k++) begin
            step();
            if (ov_smp) n_seen++;
        end
        check_val("mid_rst_no_stale", 64'(n_seen), 64'd0);
        run_one("after_rst", 32'h3FC00000, 32'h40000000, 3'd0, 32'h40400000, 6'b000000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
